// File: rtl/nand_reduce_arbiter.sv
// Round-robin arbiter sharing one tree_nand reducer among NUM_REQ valid/ready requesters.
// One operand is held in flight at a time, and the 1-bit result is returned with its requester ID.

module tree_nand #(
  parameter int W = 32
) (
  input  logic [W-1:0] d_i,
  output logic         y_o
);
  generate
    if (W == 1) begin : g_leaf1
      assign y_o = d_i[0];
    end else if (W == 2) begin : g_leaf2
      assign y_o = ~(d_i[0] & d_i[1]);
    end else begin : g_split
      localparam int LO = W / 2;
      localparam int HI = W - LO;
      logic lo_y, hi_y;
      tree_nand #(.W(LO)) u_lo (.d_i(d_i[LO-1:0]), .y_o(lo_y));
      tree_nand #(.W(HI)) u_hi (.d_i(d_i[W-1:LO]), .y_o(hi_y));
      assign y_o = ~(lo_y & hi_y);
    end
  endgenerate
endmodule

module nand_reduce_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic                     rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  input  logic                     rsp_ready,
  output logic                     busy
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

  logic [WIDTH-1:0] operand [NUM_REQ];
  logic [ID_W-1:0]  grant_idx;
  logic             accept;
  logic             tree_y;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign operand[gi]   = req_data[gi*WIDTH +: WIDTH];
      assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // First valid requester strictly after the previous grant, wrapping around.
  always_comb begin
    int  idx;
    logic found;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  // A new operand is taken only when the result register is empty or being drained.
  assign accept = !reset && (|req_valid) &&
                  ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

  tree_nand #(.W(WIDTH)) u_tree (.d_i(op_q), .y_o(tree_y));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    id_d        = id_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: begin
        rsp_data_d  = tree_y;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = accept ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      op_d   = operand[grant_idx];
      id_d   = grant_idx;
      last_d = grant_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      id_q        <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      id_q        <= id_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_nand_reduce_arbiter.sv
// Randomized and directed stimulus against a transaction-level model of the shared reducer:
// a one-deep compute slot feeding a one-deep output slot, with modulo round-robin selection.

module tb_nand_reduce_arbiter;
  localparam int W  = 4;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_data;
  logic [IW-1:0]  rsp_id;
  logic           rsp_ready;
  logic           busy;

  nand_reduce_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: compute slot, output slot, last granted index.
  bit       m_comp;
  bit [3:0] m_op;
  int       m_cid;
  bit       m_out_v;
  bit       m_out_d;
  int       m_out_id;
  int       m_last;
  bit [3:0] m_granted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_f(input bit [3:0] x);
    return (x[0] & x[1]) | (x[2] & x[3]);
  endfunction

  task automatic model_reset();
    m_comp = 0; m_op = 0; m_cid = 0;
    m_out_v = 0; m_out_d = 0; m_out_id = 0;
    m_last = N - 1; m_granted = 0;
  endtask

  // Reset asserted mid-cycle: outputs must drop immediately even with requests pending.
  task automatic pulse_reset(input logic [N-1:0] v);
    req_valid = v;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Drives one cycle of inputs, compares against the model, then advances the model one edge.
  task automatic run_cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic rr);
    bit accept;
    int g;
    logic [N-1:0] exp_ready;
    req_valid = v; req_data = d; rsp_ready = rr;
    #2;
    g = -1;
    for (int k = 1; k <= N; k++)
      if (g < 0 && v[(m_last + k) % N]) g = (m_last + k) % N;
    accept = !m_comp && (!m_out_v || rr) && (g >= 0);
    exp_ready = accept ? N'(1 << g) : '0;
    m_granted = accept ? 4'(1 << g) : 4'd0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(m_out_v));
    check("busy",      32'(busy),      32'(m_comp || m_out_v));
    if (m_out_v) begin
      check("rsp_data", 32'(rsp_data), 32'(m_out_d));
      check("rsp_id",   32'(rsp_id),   32'(m_out_id));
    end
    @(posedge clk);
    if (m_comp) begin
      m_out_v = 1; m_out_d = ref_f(m_op); m_out_id = m_cid; m_comp = 0;
    end else if (m_out_v && rr) begin
      m_out_v = 0;
    end
    if (accept) begin
      m_comp = 1; m_op = d[g*W +: W]; m_cid = g; m_last = g;
    end
    #1;
  endtask

  logic [N-1:0]   pend;
  logic [N*W-1:0] pdata;
  logic [3:0]     ftab [4];

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    #1;
    pulse_reset(4'b0001);

    // Single request from requester 2.
    run_cycle(4'b0100, 16'h0300, 1'b1);
    check("single_grant", 32'(m_granted), 32'h4);
    repeat (3) run_cycle(4'b0000, 16'h0000, 1'b1);

    // Function table from requester 0, each returning through IDLE.
    ftab[0] = 4'b0101; ftab[1] = 4'b1111; ftab[2] = 4'b0000; ftab[3] = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      run_cycle(4'b0001, {12'h000, ftab[i]}, 1'b1);
      run_cycle(4'b0000, 16'h0000, 1'b1);
      run_cycle(4'b0000, 16'h0000, 1'b1);
    end

    // Fairness: all requesters valid, back-to-back responses.
    pulse_reset(4'b0000);
    for (int i = 0; i < 11; i++) run_cycle(4'b1111, 16'hC3F5, 1'b1);
    repeat (3) run_cycle(4'b0000, 16'h0000, 1'b1);

    // Backpressure with requester 1 pending, then release.
    run_cycle(4'b0001, 16'h0003, 1'b1);
    run_cycle(4'b0000, 16'h0000, 1'b0);
    repeat (5) run_cycle(4'b0010, 16'h00A0, 1'b0);
    run_cycle(4'b0010, 16'h00A0, 1'b1);
    check("bp_grant", 32'(m_granted), 32'h2);
    repeat (3) run_cycle(4'b0000, 16'h0000, 1'b1);

    // Reset in the CALC cycle, then requester 3 from a clean IDLE.
    run_cycle(4'b0001, 16'h000F, 1'b1);
    pulse_reset(4'b1000);
    repeat (2) run_cycle(4'b0000, 16'h0000, 1'b1);
    run_cycle(4'b1000, 16'hF000, 1'b1);
    check("post_rst_grant", 32'(m_granted), 32'h8);
    repeat (3) run_cycle(4'b0000, 16'h0000, 1'b1);

    // Withdrawn request during RESP backpressure.
    run_cycle(4'b0001, 16'h0001, 1'b1);
    run_cycle(4'b0000, 16'h0000, 1'b0);
    run_cycle(4'b0010, 16'h0030, 1'b0);
    run_cycle(4'b0000, 16'h0000, 1'b0);
    run_cycle(4'b0000, 16'h0000, 1'b1);
    repeat (3) run_cycle(4'b0000, 16'h0000, 1'b1);

    // Random traffic; requesters hold valid/data until granted, occasionally withdraw.
    pend = '0; pdata = '0;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          pdata[i*W +: W] = W'($urandom);
        end else if (pend[i] && $urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 249) == 0) begin
        pulse_reset(pend);
      end else begin
        run_cycle(pend, pdata, $urandom_range(0, 9) < 7);
        pend = pend & ~m_granted;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nand_reduce_arbiter.md
# nand_reduce_arbiter

Shares one `tree_nand` reduction datapath among `NUM_REQ` requesters. Each requester offers a `WIDTH`-bit operand over a valid/ready handshake. A round-robin arbiter grants one requester at a time and latches its operand into a register that feeds the `tree_nand` instance. The block registers the 1-bit result and returns it with the requester ID over a valid/ready response channel. It sits between reduction clients (condition/flag collectors) and the single shared reducer.

## Interface
- `WIDTH`, 32: operand width; passed unchanged to the `tree_nand` instance; must be ≥ 1.
- `NUM_REQ`, 4: number of requesters; must be ≥ 2.
- `ID_W`, 2: ID width; must equal clog2(`NUM_REQ`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  bit i set: requester i offers an operand.
- `req_data`  in  `NUM_REQ`*`WIDTH`  operand i is slice [i*`WIDTH` +: `WIDTH`].
- `req_ready`  out  `NUM_REQ`  one-hot or zero; bit i set means requester i's operand is accepted this cycle.
- `rsp_valid`  out  1  result available.
- `rsp_data`  out  1  `tree_nand` result of the granted operand.
- `rsp_id`  out  `ID_W`  index of the requester that produced `rsp_data`.
- `rsp_ready`  in  1  consumer accepts the response.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Reduction function (`tree_nand`):**
  - Width 1: passthrough.
  - Width 2: d0 NAND d1.
  - Otherwise: NAND of the low-half result (`WIDTH`/2 bits) and the high-half result (remaining bits).
- **FSM states:** IDLE, CALC, RESP.
- **IDLE:**
  - If any `req_valid` is set, grant requester g, chosen round-robin as the first set bit after `last_grant`, scanning upward with wrap.
  - Assert `req_ready[g]` combinationally that cycle.
  - Latch operand g into `op_reg` and g into `id_reg`.
  - Set `last_grant` to g. Go to CALC.
- **CALC:**
  - `rsp_data` <= `tree_nand`(`op_reg`); `rsp_id` <= `id_reg`; `rsp_valid` <= 1. Go to RESP.
  - `req_ready` = 0 in this state.
- **RESP:** hold `rsp_valid`, `rsp_data` and `rsp_id` stable until `rsp_ready`.
  - If `rsp_ready`=1 and any `req_valid`=1 in the same cycle: accept the next grant exactly as in IDLE, clear `rsp_valid`, go to CALC (back-to-back).
  - If `rsp_ready`=1 and no `req_valid`: clear `rsp_valid`, go to IDLE.
  - If `rsp_ready`=0: `req_ready` = 0.
- `req_ready` is never asserted for a requester whose `req_valid` is 0.
- At most one `req_ready` bit is high in any cycle.
- Requesters hold valid and data stable until their ready. The arbiter re-evaluates every cycle, so a dropped `req_valid` only removes that requester from contention.
- Round-robin: a requester that keeps `req_valid` high is granted within `NUM_REQ` grants.
- Arbitration uses `req_valid` only; operand values never affect the grant.

## Timing
- **Reset values:** state=IDLE, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `op_reg`=0, `id_reg`=0, `busy`=0, `last_grant`=`NUM_REQ`-1 (requester 0 has first priority). `req_ready`=0 while `reset` is high.
- **Latency:** handshake at edge t, `rsp_valid` high after edge t+2 (visible in cycle t+2).
- **Throughput:** one result per 2 cycles with `rsp_ready` held high; 3 cycles when each transaction returns through IDLE.
- **Reset during CALC or RESP:** the in-flight result is discarded and nothing is emitted afterwards. The requester's handshake already completed, so no replay occurs.
- The `tree_nand` path is purely combinational from `op_reg` to the `rsp_data` D input: one full cycle budget.

## Test plan
Bench settings: `WIDTH`=4, `NUM_REQ`=4, `ID_W`=2. For `WIDTH`=4, f(d) = (d0&d1)|(d2&d3).
- **Single request:** req 2 valid with data 4'b0011, `rsp_ready`=1.
  - `req_ready`=4'b0100 in cycle 0.
  - Cycle 2: `rsp_valid`=1, `rsp_data`=1, `rsp_id`=2.
  - Then IDLE, `busy`=0.
- **Function table:** data 4'b0101, 4'b1111, 4'b0000, 4'b1100 from req 0 → `rsp_data` 0, 1, 0, 1 respectively.
- **Fairness:** all four `req_valid` held high with distinct data, `rsp_ready`=1.
  - Grant order 0,1,2,3,0.
  - `rsp_valid` in cycles 2, 4, 6, 8, 10 (2-cycle spacing), with matching `rsp_id`.
- **Backpressure:** `rsp_ready`=0 for 5 cycles after `rsp_valid`.
  - `rsp_valid`, `rsp_data` and `rsp_id` stay constant; `req_ready`=0 throughout.
  - On `rsp_ready`=1 with req 1 pending, `req_ready`=4'b0010 in that same cycle.
- **Reset mid-operation:** assert `reset` in the CALC cycle.
  - All outputs immediately at reset values; no `rsp_valid` afterwards.
  - The next request from req 3 after reset is granted in IDLE, unaffected by the aborted grant.
- **Withdrawn request:** req 1 valid for one cycle while the block is in RESP with `rsp_ready`=0, then dropped.
  - Req 1 is never granted.
  - `req_ready` stays 4'b0000.
